// File: rtl/pupil_pkg.sv
// Shared definitions for the pupil locator: FSM state encoding, datapath
// widths and the default frame geometry / dark threshold (the frame-save
// stage uses the same defaults so both sides agree on the buffer layout).
package pupil_pkg;

    // Scan controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DRAIN = 3'd2,
        DIV_X = 3'd3,
        DIV_Y = 3'd4,
        DONE  = 3'd5
    } pupilState_t;

    localparam int ADDR_W    = 15;  // frame-buffer address / coordinate counters
    localparam int CNT_W     = 15;  // dark-pixel count, also the divisor width
    localparam int SUM_W     = 22;  // coordinate sums
    localparam int QUO_W     = 22;  // quotient width (one bit per divider step)
    localparam int COORD_W   = 13;  // reported centroid / box coordinates
    localparam int PIX_W     = 10;  // pixel value width
    localparam int DIV_STEPS = 22;  // divider iterations per quotient

    localparam int                H_RES_DEF     = 160;
    localparam int                V_RES_DEF     = 120;
    localparam logic [PIX_W-1:0]  THRESHOLD_DEF = 10'd96;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   iCLK, iRST   clock and asynchronous active-high reset
//   iStart       load operands; the first iteration runs on the next edge
//   iDividend    22-bit dividend
//   iDivisor     15-bit divisor (caller guarantees non-zero)
//   oDone        high during the cycle whose closing edge performs the last step;
//                oQuotient is final from the following cycle and held until iStart
//   oQuotient    truncating quotient
module seq_divider
    import pupil_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic [QUO_W-1:0]  iDividend,
    input  logic [CNT_W-1:0]  iDivisor,
    output logic              oDone,
    output logic [QUO_W-1:0]  oQuotient
);

    localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

    logic [QUO_W-1:0] quot_r;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] div_r;
    logic [4:0]       step_r;
    logic             run_r;

    logic [CNT_W:0]   shifted_s;
    logic [CNT_W:0]   diff_s;
    logic [CNT_W:0]   remNext_s;
    logic             ge_s;
    logic             unusedRemTop_s;

    // One restoring step: shift the next dividend bit into the remainder and subtract if it fits
    always_comb begin
        shifted_s = {rem_r, quot_r[QUO_W-1]};
        diff_s    = shifted_s - {1'b0, div_r};
        ge_s      = (shifted_s >= {1'b0, div_r});
        if (ge_s) begin
            remNext_s = diff_s;
        end else begin
            remNext_s = shifted_s;
        end
    end

    // The remainder always ends below the divisor, so its top bit is never kept
    assign unusedRemTop_s = remNext_s[CNT_W];

    assign oDone     = run_r && (step_r == LAST_STEP);
    assign oQuotient = quot_r;

    // Operand load and iteration; quotient bits shift in as dividend bits shift out
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            quot_r <= {QUO_W{1'b0}};
            rem_r  <= {CNT_W{1'b0}};
            div_r  <= {CNT_W{1'b0}};
            step_r <= 5'd0;
            run_r  <= 1'b0;
        end else if (iStart) begin
            quot_r <= iDividend;
            rem_r  <= {CNT_W{1'b0}};
            div_r  <= iDivisor;
            step_r <= 5'd0;
            run_r  <= 1'b1;
        end else if (run_r) begin
            quot_r <= {quot_r[QUO_W-2:0], ge_s};
            rem_r  <= remNext_s[CNT_W-1:0];
            step_r <= step_r + 5'd1;
            run_r  <= !oDone;
        end
    end

endmodule

// File: rtl/pupil_locator.sv
// Pupil locator: scans a stored frame, counts pixels darker than THRESHOLD
// and reports their centroid (sumX/count, sumY/count).
// Ports:
//   iCLK, iRST        clock, asynchronous active-high reset
//   iStart            start pulse (ignored while oBusy)
//   oMemAddr/oMemRE   frame-buffer read port, address = x + H_RES*y
//   iMemData          pixel value, valid one cycle after oMemRE
//   oBusy             scan/divide in progress
//   oValid            one-cycle pulse when results update
//   oFound, oPupilX, oPupilY, oDarkCount   held results of the last scan
// Optional macro PUPIL_BBOX_EN adds oBoxXMin/oBoxXMax/oBoxYMin/oBoxYMax,
// the dark-pixel bounding box (zero when nothing was found).
module pupil_locator
    import pupil_pkg::*;
#(
    parameter int               H_RES     = H_RES_DEF,
    parameter int               V_RES     = V_RES_DEF,
    parameter logic [PIX_W-1:0] THRESHOLD = THRESHOLD_DEF
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iStart,
    output logic [ADDR_W-1:0]   oMemAddr,
    output logic                oMemRE,
    input  logic [PIX_W-1:0]    iMemData,
    output logic                oBusy,
    output logic                oValid,
    output logic                oFound,
    output logic [COORD_W-1:0]  oPupilX,
    output logic [COORD_W-1:0]  oPupilY,
    output logic [CNT_W-1:0]    oDarkCount
`ifdef PUPIL_BBOX_EN
    ,
    output logic [COORD_W-1:0]  oBoxXMin,
    output logic [COORD_W-1:0]  oBoxXMax,
    output logic [COORD_W-1:0]  oBoxYMin,
    output logic [COORD_W-1:0]  oBoxYMax
`endif
);

    localparam int                 NPIX      = H_RES * V_RES;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0]  X_LAST    = ADDR_W'(H_RES - 1);

    pupilState_t        state_r, stateNext_s;
    logic [ADDR_W-1:0]  memAddr_r, x_r, y_r, xD_r, yD_r;
    logic               memRe_r, validD_r, busy_r, divLaunch_r;
    logic [CNT_W-1:0]   count_r, countNext_s;
    logic [SUM_W-1:0]   sumX_r, sumY_r;
    logic [COORD_W-1:0] quotX_r;
    logic               darkHit_s, lastAddr_s, startAcc_s, found_s;
    logic [QUO_W-1:0]   divDividend_s, divQuot_s;
    logic               divDone_s;
    logic               unusedQuotHi_s;

    // Dark-pixel detection on the aligned pipeline, next count, divider operand select
    always_comb begin
        darkHit_s  = validD_r && (iMemData < THRESHOLD);
        lastAddr_s = (memAddr_r == LAST_ADDR);
        startAcc_s = (state_r == IDLE) && iStart;
        found_s    = (count_r != {CNT_W{1'b0}});
        if (darkHit_s) begin
            countNext_s = count_r + 15'd1;
        end else begin
            countNext_s = count_r;
        end
        if (state_r == DIV_Y) begin
            divDividend_s = sumY_r;
        end else begin
            divDividend_s = sumX_r;
        end
    end

    // Next-state logic; DRAIN looks at countNext_s because the last pixel lands on its closing edge
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (iStart) stateNext_s = SCAN;
                else        stateNext_s = IDLE;
            end
            SCAN: begin
                if (lastAddr_s) stateNext_s = DRAIN;
                else            stateNext_s = SCAN;
            end
            DRAIN: begin
                if (countNext_s != {CNT_W{1'b0}}) stateNext_s = DIV_X;
                else                              stateNext_s = DONE;
            end
            DIV_X: begin
                if (divDone_s) stateNext_s = DIV_Y;
                else           stateNext_s = DIV_X;
            end
            DIV_Y: begin
                if (divDone_s) stateNext_s = DONE;
                else           stateNext_s = DIV_Y;
            end
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // State register, busy flag, and a one-cycle divider launch on entry to each divide state
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            divLaunch_r <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            busy_r      <= (stateNext_s != IDLE);
            divLaunch_r <= ((stateNext_s == DIV_X) && (state_r != DIV_X)) ||
                           ((stateNext_s == DIV_Y) && (state_r != DIV_Y));
        end
    end

    // Read-address generator; the address holds once the scan ends
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            memAddr_r <= {ADDR_W{1'b0}};
            x_r       <= {ADDR_W{1'b0}};
            y_r       <= {ADDR_W{1'b0}};
            memRe_r   <= 1'b0;
        end else if (startAcc_s) begin
            memAddr_r <= {ADDR_W{1'b0}};
            x_r       <= {ADDR_W{1'b0}};
            y_r       <= {ADDR_W{1'b0}};
            memRe_r   <= 1'b1;
        end else if ((state_r == SCAN) && !lastAddr_s) begin
            memAddr_r <= memAddr_r + 15'd1;
            memRe_r   <= 1'b1;
            if (x_r == X_LAST) begin
                x_r <= {ADDR_W{1'b0}};
                y_r <= y_r + 15'd1;
            end else begin
                x_r <= x_r + 15'd1;
            end
        end else begin
            memRe_r <= 1'b0;
        end
    end

    // Coordinate delay line and accumulators; coordinates trail the address by the read latency
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            xD_r     <= {ADDR_W{1'b0}};
            yD_r     <= {ADDR_W{1'b0}};
            validD_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            sumX_r   <= {SUM_W{1'b0}};
            sumY_r   <= {SUM_W{1'b0}};
        end else begin
            xD_r     <= x_r;
            yD_r     <= y_r;
            validD_r <= memRe_r;
            if (startAcc_s) begin
                count_r <= {CNT_W{1'b0}};
                sumX_r  <= {SUM_W{1'b0}};
                sumY_r  <= {SUM_W{1'b0}};
            end else if (darkHit_s) begin
                count_r <= countNext_s;
                sumX_r  <= sumX_r + SUM_W'(xD_r);
                sumY_r  <= sumY_r + SUM_W'(yD_r);
            end
        end
    end

    seq_divider uDiv (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iStart    (divLaunch_r),
        .iDividend (divDividend_s),
        .iDivisor  (count_r),
        .oDone     (divDone_s),
        .oQuotient (divQuot_s)
    );

    // Centroids never exceed the frame width, so the high quotient bits are always zero
    assign unusedQuotHi_s = ^divQuot_s[QUO_W-1:COORD_W];

    // Result registers; the X quotient is captured as the Y division is launched
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            quotX_r    <= {COORD_W{1'b0}};
            oValid     <= 1'b0;
            oFound     <= 1'b0;
            oPupilX    <= {COORD_W{1'b0}};
            oPupilY    <= {COORD_W{1'b0}};
            oDarkCount <= {CNT_W{1'b0}};
        end else begin
            oValid <= (state_r == DONE);
            if ((state_r == DIV_Y) && divLaunch_r) begin
                quotX_r <= divQuot_s[COORD_W-1:0];
            end
            if (state_r == DONE) begin
                oFound     <= found_s;
                oDarkCount <= count_r;
                if (found_s) begin
                    oPupilX <= quotX_r;
                    oPupilY <= divQuot_s[COORD_W-1:0];
                end else begin
                    oPupilX <= {COORD_W{1'b0}};
                    oPupilY <= {COORD_W{1'b0}};
                end
            end
        end
    end

`ifdef PUPIL_BBOX_EN
    logic [COORD_W-1:0] xMin_r, xMax_r, yMin_r, yMax_r;

    // Bounding-box tracking; min starts at all-ones and max at zero for each scan
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            xMin_r   <= {COORD_W{1'b1}};
            xMax_r   <= {COORD_W{1'b0}};
            yMin_r   <= {COORD_W{1'b1}};
            yMax_r   <= {COORD_W{1'b0}};
            oBoxXMin <= {COORD_W{1'b0}};
            oBoxXMax <= {COORD_W{1'b0}};
            oBoxYMin <= {COORD_W{1'b0}};
            oBoxYMax <= {COORD_W{1'b0}};
        end else begin
            if (startAcc_s) begin
                xMin_r <= {COORD_W{1'b1}};
                xMax_r <= {COORD_W{1'b0}};
                yMin_r <= {COORD_W{1'b1}};
                yMax_r <= {COORD_W{1'b0}};
            end else if (darkHit_s) begin
                if (xD_r[COORD_W-1:0] < xMin_r) xMin_r <= xD_r[COORD_W-1:0];
                if (xD_r[COORD_W-1:0] > xMax_r) xMax_r <= xD_r[COORD_W-1:0];
                if (yD_r[COORD_W-1:0] < yMin_r) yMin_r <= yD_r[COORD_W-1:0];
                if (yD_r[COORD_W-1:0] > yMax_r) yMax_r <= yD_r[COORD_W-1:0];
            end
            if (state_r == DONE) begin
                if (found_s) begin
                    oBoxXMin <= xMin_r;
                    oBoxXMax <= xMax_r;
                    oBoxYMin <= yMin_r;
                    oBoxYMax <= yMax_r;
                end else begin
                    oBoxXMin <= {COORD_W{1'b0}};
                    oBoxXMax <= {COORD_W{1'b0}};
                    oBoxYMin <= {COORD_W{1'b0}};
                    oBoxYMax <= {COORD_W{1'b0}};
                end
            end
        end
    end
`endif

    assign oMemAddr = memAddr_r;
    assign oMemRE   = memRe_r;
    assign oBusy    = busy_r;

endmodule

// File: tb/tb_pupil_locator.sv
// Scoreboard bench for pupil_locator at the default 160x120 geometry.
// Stimulus pushes hand-computed expectations; a monitor forked from the main
// process pops and compares on every oValid, and also tracks the read-address
// sequence of each scan.
module tb_pupil_locator;

    localparam int H         = 160;
    localparam int V         = 120;
    localparam int NPIX      = H * V;
    localparam int LAT_FULL  = NPIX + 2 + 2 * (22 + 1) + 1;
    localparam int LAT_SHORT = NPIX + 2 + 1;

    typedef struct {
        int found;
        int count;
        int x;
        int y;
        int cyc;
        int bx0;
        int bx1;
        int by0;
        int by1;
    } exp_t;

    logic        iCLK   = 1'b0;
    logic        iRST   = 1'b1;
    logic        iStart = 1'b0;
    logic [14:0] oMemAddr;
    logic        oMemRE;
    logic [9:0]  memData = 10'd1023;
    logic        oBusy, oValid, oFound;
    logic [12:0] oPupilX, oPupilY;
    logic [14:0] oDarkCount;
`ifdef PUPIL_BBOX_EN
    logic [12:0] oBoxXMin, oBoxXMax, oBoxYMin, oBoxYMax;
`endif

    logic [9:0]  mem [0:NPIX-1];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        expQ[$];

    pupil_locator dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iStart     (iStart),
        .oMemAddr   (oMemAddr),
        .oMemRE     (oMemRE),
        .iMemData   (memData),
        .oBusy      (oBusy),
        .oValid     (oValid),
        .oFound     (oFound),
        .oPupilX    (oPupilX),
        .oPupilY    (oPupilY),
        .oDarkCount (oDarkCount)
`ifdef PUPIL_BBOX_EN
        ,
        .oBoxXMin   (oBoxXMin),
        .oBoxXMax   (oBoxXMax),
        .oBoxYMin   (oBoxYMin),
        .oBoxYMax   (oBoxYMax)
`endif
    );

    always #5 iCLK = ~iCLK;

    // Cycle counter used for latency checks
    always @(posedge iCLK) cyc <= cyc + 1;

    // Frame buffer with one-cycle read latency
    always @(posedge iCLK) if (oMemRE) memData <= mem[oMemAddr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kind 0: all bright; 1: 10x10 black block at x 40..49, y 30..39;
    // 2: value 95 at the last pixel, value 96 (not dark) at pixel 0 and mid-frame
    task automatic setImage(input int kind);
        for (int a = 0; a < NPIX; a++) begin
            mem[a] = 10'd1023;
            if (kind == 1 && (a % H) >= 40 && (a % H) <= 49 && (a / H) >= 30 && (a / H) <= 39)
                mem[a] = 10'd0;
            if (kind == 2 && a == NPIX - 1) mem[a] = 10'd95;
            if (kind == 2 && (a == 0 || a == 9000)) mem[a] = 10'd96;
        end
    endtask

    task automatic monitor();
        int   expAddr = 0;
        int   reCount = 0;
        int   addrErr = 0;
        bit   prevRe  = 1'b0;
        exp_t e;
        forever begin
            @(negedge iCLK);
            if (oMemRE) begin
                if (!prevRe) begin
                    expAddr = 0;
                    reCount = 0;
                    addrErr = 0;
                end
                if (int'(oMemAddr) != expAddr) addrErr++;
                expAddr++;
                reCount++;
            end
            prevRe = oMemRE;
            if (oValid) begin
                if (expQ.size() == 0) begin
                    chk("spurious_oValid", int'(oValid), 0);
                end else begin
                    e = expQ.pop_front();
                    chk("oFound",      int'(oFound),     e.found);
                    chk("oDarkCount",  int'(oDarkCount), e.count);
                    chk("oPupilX",     int'(oPupilX),    e.x);
                    chk("oPupilY",     int'(oPupilY),    e.y);
                    chk("valid_cycle", cyc,              e.cyc);
                    chk("scan_reads",  reCount,          NPIX);
                    chk("addr_order_errors", addrErr,    0);
`ifdef PUPIL_BBOX_EN
                    chk("oBoxXMin", int'(oBoxXMin), e.bx0);
                    chk("oBoxXMax", int'(oBoxXMax), e.bx1);
                    chk("oBoxYMin", int'(oBoxYMin), e.by0);
                    chk("oBoxYMax", int'(oBoxYMax), e.by1);
`endif
                end
            end
        end
    endtask

    // e.cyc carries the latency on entry; it is turned into an absolute cycle here
    task automatic startScan(input bit pushExp, input exp_t e);
        @(negedge iCLK);
        iStart = 1'b1;
        if (pushExp) begin
            e.cyc = cyc + e.cyc;
            expQ.push_back(e);
        end
        @(negedge iCLK);
        iStart = 1'b0;
    endtask

    task automatic waitEmpty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0) break;
            @(negedge iCLK);
        end
        chk("pending_results_after_wait", expQ.size(), 0);
    endtask

    exp_t e;

    initial begin
        fork
            monitor();
        join_none

        setImage(0);
        repeat (3) @(negedge iCLK);
        chk("rst_oMemAddr",   int'(oMemAddr),   0);
        chk("rst_oMemRE",     int'(oMemRE),     0);
        chk("rst_oBusy",      int'(oBusy),      0);
        chk("rst_oValid",     int'(oValid),     0);
        chk("rst_oFound",     int'(oFound),     0);
        chk("rst_oPupilX",    int'(oPupilX),    0);
        chk("rst_oPupilY",    int'(oPupilY),    0);
        chk("rst_oDarkCount", int'(oDarkCount), 0);
        iRST = 1'b0;
        @(negedge iCLK);

        // All bright: nothing found, divides skipped
        e = '{0, 0, 0, 0, LAT_SHORT, 0, 0, 0, 0};
        startScan(1'b1, e);
        waitEmpty(LAT_FULL + 100);

        // Black block, centroid 44.5/34.5 truncates to 44/34; a second start mid-scan is ignored
        setImage(1);
        e = '{1, 100, 44, 34, LAT_FULL, 40, 49, 30, 39};
        startScan(1'b1, e);
        repeat (49) @(negedge iCLK);
        chk("busy_during_scan", int'(oBusy), 1);
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        waitEmpty(LAT_FULL + 100);

        // Reset while dividing X: no result may appear for the abandoned scan
        startScan(1'b0, e);
        repeat (NPIX + 10) @(negedge iCLK);
        chk("busy_in_div",  int'(oBusy),  1);
        chk("re_low_in_div", int'(oMemRE), 0);
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);
        chk("midrst_oBusy",      int'(oBusy),      0);
        chk("midrst_oValid",     int'(oValid),     0);
        chk("midrst_oFound",     int'(oFound),     0);
        chk("midrst_oDarkCount", int'(oDarkCount), 0);
        chk("midrst_oMemAddr",   int'(oMemAddr),   0);
        iRST = 1'b0;
        repeat (100) @(negedge iCLK);

        // Fresh scan: only the last pixel (95) is dark; 96 does not count
        setImage(2);
        e = '{1, 1, 159, 119, LAT_FULL, 159, 159, 119, 119};
        startScan(1'b1, e);
        waitEmpty(LAT_FULL + 100);
        repeat (60) @(negedge iCLK);
        chk("final_queue_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pupil_locator.md
PUPIL_LOCATOR -- requirements
Module: pupil_locator

Interface
REQ-001 Parameter H_RES, default 160: stored frame width in pixels.
REQ-002 Parameter V_RES, default 120: stored frame height in pixels; H_RES*V_RES SHALL be at most 32768.
REQ-003 Parameter THRESHOLD, default 10'd96: pixel values strictly below this are dark (pupil candidates).
REQ-004 iCLK  in  1  single clock, rising edge.
REQ-005 iRST  in  1  reset; asynchronous assertion, active-high.
REQ-006 iStart  in  1  single-cycle pulse; the frame buffer is complete and the scan may begin.
REQ-007 oMemAddr  out  15  frame-buffer read address; address = x + H_RES*y.
REQ-008 oMemRE  out  1  read enable; iMemData SHALL be valid exactly one cycle after oMemRE=1.
REQ-009 iMemData  in  10  pixel value, red channel.
REQ-010 oBusy  out  1  high from the cycle after the accepted iStart until oValid.
REQ-011 oValid  out  1  one-cycle pulse; the result is updated.
REQ-012 oFound  out  1  at least one dark pixel in the last scan; held until the next oValid.
REQ-013 oPupilX / oPupilY  out  13 each  dark-pixel centroid, zero-extended, held until the next oValid.
REQ-014 oDarkCount  out  15  number of dark pixels in the last scan, held.

Function
REQ-015 States: IDLE, SCAN, DRAIN, DIV_X, DIV_Y, DONE.
- IDLE->SCAN on iStart.
- SCAN->DRAIN after address H_RES*V_RES-1 is issued.
- DRAIN->DIV_X after one cycle.
- DIV_X->DIV_Y->DONE, each on divider done.
- DONE->IDLE after one cycle.
REQ-016 SCAN: issue one address per cycle with oMemRE=1, starting at 0 and ascending; x/y counters wrap x at H_RES-1 and increment y.
REQ-017 Pipeline: x/y SHALL be delayed one cycle to align with iMemData.
- For each pixel with iMemData < THRESHOLD: count+=1, sumX+=x, sumY+=y.
- Accumulators: 15-bit count; 22-bit sumX and sumY. No overflow is possible at the maximum frame size.
REQ-018 If count==0 on leaving DRAIN: skip DIV_X and DIV_Y; go to DONE with oFound=0 and oPupilX=oPupilY=0.
REQ-019 Division: truncating unsigned quotients sumX/count and sumY/count.
- Sequential, 1 quotient bit per cycle, 22 cycles per division.
REQ-020 DONE: register the outputs and pulse oValid. Total latency from iStart to oValid is H_RES*V_RES+2+2*(22+1)+1 cycles when count>0.
REQ-021 iStart SHALL be ignored while oBusy=1, including in the DONE cycle.
REQ-022 oMemRE SHALL be 0 outside SCAN; oMemAddr SHALL hold its last value.

Reset
REQ-023 On iRST: state=IDLE and all accumulators cleared.
- Outputs: oMemAddr=0, oMemRE=0, oBusy=0, oValid=0, oFound=0, oPupilX=0, oPupilY=0, oDarkCount=0.
REQ-024 Reset mid-scan or mid-divide SHALL abandon the operation; no oValid is produced for it.

Configuration
REQ-025 Macro PUPIL_BBOX_EN defined: the block tracks the dark-pixel bounding box.
- Extra outputs oBoxXMin, oBoxXMax, oBoxYMin, oBoxYMax, each 13 bits, updated at oValid.
- Box values are 0 when oFound=0.
- Registers initialise to min=all-ones and max=0 at iStart.
REQ-026 Macro undefined: those ports and registers SHALL NOT exist; all other behaviour is identical.

Structure
REQ-027 Shared package pupil_pkg holds:
- the state enumeration;
- the accumulator and quotient width constants;
- the default H_RES, V_RES and THRESHOLD values, which the frame-save stage also uses.
REQ-028 One sub-module, seq_divider (22-bit dividend, 15-bit divisor, start/done handshake), SHALL be instantiated once and reused for X and Y.

Verification
REQ-029 All pixels 1023 except a 10x10 block of value 0 at x=40..49, y=30..39; pulse iStart.
- Expect oFound=1, oDarkCount=100, oPupilX=44, oPupilY=34.
REQ-030 All pixels 1023 -> oFound=0, oDarkCount=0, oPupilX=oPupilY=0, and oValid at the shortened latency.
REQ-031 Single dark pixel at address 19199 -> oPupilX=159, oPupilY=119, oDarkCount=1.
- Boundary case: pixel value THRESHOLD-1 counts as dark; value THRESHOLD does not.
REQ-032 Second iStart 50 cycles into SCAN -> ignored; exactly one oValid; oMemAddr sequence is 0..19199 with no repeats.
REQ-033 iRST asserted mid-DIV_X, then iStart after release -> no stale oValid; the fresh scan result is correct.
REQ-034 With PUPIL_BBOX_EN and the REQ-029 image -> box (40,49,30,39).
